mem_spi_flash_responder: RTL and testbench

Synthesizable SPI/QSPI NOR-flash target that models the far end of the memory interface's SPI controller link (CS_n, SCLK, IO[3:0]). It oversamples the controller's pins on the system clock, decodes a Winbond-style command subset and serves reads and programs from an internal byte array. It is the bench and FPGA-loopback partner for the transaction FSM and SPI controller, exercising single and quad reads, the QE status bit and page program without an external flash part.

---
 rtl/mem_spi_flash_responder.sv | 212 +++++++++++++++++++++
 tb/tb_mem_spi_flash_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_spi_flash_responder.sv
// SPI/QSPI NOR-flash target: oversamples the controller pins on clk, decodes a
// Winbond-style command subset and serves reads/programs from a byte array.
module mem_spi_flash_responder #(
  parameter int ADDR_BITS    = 8,
  parameter bit QE_INIT      = 1'b0,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_cs_n,
  input  logic       in_sclk,
  input  logic [3:0] in_io,
  output logic [3:0] out_io,
  output logic [3:0] out_io_oe,
  output logic       out_qe,
  output logic       out_wel
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PMASK = ADDR_BITS'(255);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_QDATA, S_SRDATA, S_SRWR, S_PGDATA, S_IGNORE
  } state_t;

  logic [5:0] s1_q, s2_q;
  logic       cs_prev_q, sclk_prev_q;
  logic       cs_n_s, cs_rise, cs_fall, sck_rise, sck_fall, mosi, unused_io;

  // CS chain resets low so a select held across reset is never seen as a new command
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      s1_q        <= {in_cs_n, in_sclk, in_io};
      s2_q        <= s1_q;
      cs_prev_q   <= s2_q[5];
      sclk_prev_q <= s2_q[4];
    end
  end

  assign cs_n_s    = s2_q[5];
  assign mosi      = s2_q[0];
  assign unused_io = ^s2_q[3:1];
  assign cs_rise   = cs_n_s & ~cs_prev_q;
  assign cs_fall   = ~cs_n_s & cs_prev_q;
  assign sck_rise  = ~cs_n_s & s2_q[4] & ~sclk_prev_q;
  assign sck_fall  = ~cs_n_s & ~s2_q[4] & sclk_prev_q;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d, shin_q, shin_d, txsh_q, txsh_d, cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [2:0]             txcnt_q, txcnt_d;
  logic [3:0]             io_q, io_d;
  logic                   wel_q, wel_d, qe_q, qe_d;
  logic [7:0]             mem_q [DEPTH];
  logic [7:0]             byte_in, rd_byte;
  logic                   mem_we, erase;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shin_q  <= '0;
      txsh_q  <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      txcnt_q <= '0;
      io_q    <= '0;
      wel_q   <= 1'b0;
      qe_q    <= QE_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shin_q  <= shin_d;
      txsh_q  <= txsh_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      txcnt_q <= txcnt_d;
      io_q    <= io_d;
      wel_q   <= wel_d;
      qe_q    <= qe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || erase) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'hFF;
    end else if (mem_we) begin
      mem_q[addr_q] <= mem_q[addr_q] & byte_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shin_d  = shin_q;
    txsh_d  = txsh_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    txcnt_d = txcnt_q;
    io_d    = io_q;
    wel_d   = wel_q;
    qe_d    = qe_q;
    mem_we  = 1'b0;
    erase   = 1'b0;
    byte_in = {shin_q[6:0], mosi};
    rd_byte = (state_q == S_SRDATA) ? {6'b0, (cmd_q == 8'h05) ? wel_q : qe_q, 1'b0}
                                    : mem_q[addr_q];
    // cmd_q holds only fully received opcodes, so CS-rise effects need no state check
    if (cs_rise) begin
      state_d = S_IDLE;
      cmd_d   = '0;
      io_d    = '0;
      case (cmd_q)
        8'h06:                      wel_d = 1'b1;
        8'h04, 8'h31, 8'h02:        wel_d = 1'b0;
        8'hC7, 8'h60: if (wel_q) begin
          erase = 1'b1;
          wel_d = 1'b0;
        end
        default: ;
      endcase
    end else if (state_q == S_IDLE) begin
      if (cs_fall) begin
        state_d = S_CMD;
        cnt_d   = '0;
        cmd_d   = '0;
      end
    end else if (sck_rise) begin
      shin_d = byte_in;
      cnt_d  = cnt_q + 8'd1;
      case (state_q)
        S_CMD: if (cnt_q == 8'd7) begin
          cmd_d   = byte_in;
          cnt_d   = '0;
          txcnt_d = '0;
          case (byte_in)
            8'h05, 8'h35: state_d = S_SRDATA;
            8'h31:        state_d = S_SRWR;
            8'h03:        state_d = S_ADDR;
            8'h6B:        state_d = qe_q ? S_ADDR : S_IGNORE;
            8'h02:        state_d = wel_q ? S_ADDR : S_IGNORE;
            default:      state_d = S_IGNORE;
          endcase
        end
        S_ADDR: begin
          addr_d = ADDR_BITS'({addr_q, mosi});
          if (cnt_q == 8'd23) begin
            cnt_d   = '0;
            txcnt_d = '0;
            case (cmd_q)
              8'h03:   state_d = S_RDATA;
              8'h6B:   state_d = (DUMMY_CYCLES == 0) ? S_QDATA : S_DUMMY;
              default: state_d = S_PGDATA;
            endcase
          end
        end
        S_DUMMY: if (cnt_q == 8'(DUMMY_CYCLES - 1)) state_d = S_QDATA;
        S_SRWR: if (cnt_q == 8'd7) begin
          if (wel_q) qe_d = byte_in[1];
          state_d = S_IGNORE;
        end
        S_PGDATA: if (cnt_q == 8'd7) begin
          mem_we = 1'b1;
          cnt_d  = '0;
          addr_d = (addr_q & ~PMASK) | ((addr_q + ADDR_BITS'(1)) & PMASK);
        end
        default: ;
      endcase
    end else if (sck_fall) begin
      case (state_q)
        S_RDATA, S_SRDATA: begin
          txcnt_d = txcnt_q + 3'd1;
          if (txcnt_q == 3'd0) begin
            io_d   = {2'b0, rd_byte[7], 1'b0};
            txsh_d = {rd_byte[6:0], 1'b0};
            if (state_q == S_RDATA) addr_d = addr_q + ADDR_BITS'(1);
          end else begin
            io_d   = {2'b0, txsh_q[7], 1'b0};
            txsh_d = {txsh_q[6:0], 1'b0};
          end
        end
        S_QDATA: begin
          txcnt_d = {2'b0, ~txcnt_q[0]};
          if (!txcnt_q[0]) begin
            io_d   = mem_q[addr_q][7:4];
            txsh_d = {mem_q[addr_q][3:0], 4'b0};
            addr_d = addr_q + ADDR_BITS'(1);
          end else begin
            io_d   = txsh_q[7:4];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_RDATA, S_SRDATA: out_io_oe = 4'b0010;
      S_QDATA:           out_io_oe = 4'b1111;
      default:           out_io_oe = 4'b0000;
    endcase
  end

  assign out_io  = io_q;
  assign out_qe  = qe_q;
  assign out_wel = wel_q;
endmodule

// File: tb/tb_mem_spi_flash_responder.sv
// Bench for mem_spi_flash_responder: directed vector table, abort sequences and
// randomized transactions checked against a byte-array flash model.
module tb_mem_spi_flash_responder;
  localparam int AB  = 8;
  localparam int DUM = 8;

  logic       clk = 1'b0, rst = 1'b1, in_cs_n = 1'b1, in_sclk = 1'b0;
  logic [3:0] in_io = 4'h0;
  logic [3:0] out_io, out_io_oe;
  logic       out_qe, out_wel;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_spi_flash_responder #(.ADDR_BITS(AB), .QE_INIT(1'b0), .DUMMY_CYCLES(DUM)) dut (
    .clk(clk), .rst(rst), .in_cs_n(in_cs_n), .in_sclk(in_sclk), .in_io(in_io),
    .out_io(out_io), .out_io_oe(out_io_oe), .out_qe(out_qe), .out_wel(out_wel)
  );

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          n;
    logic [31:0] data;
    logic [31:0] exp;
    logic [3:0]  exp_oe;
    logic        exp_wel;
    logic        exp_qe;
  } vec_t;

  vec_t        tbl [$];
  logic [7:0]  m_mem [256];
  logic        m_wel, m_qe;
  logic [31:0] rx, exp, data;
  logic [23:0] addr;
  logic [7:0]  op, b;
  logic [3:0]  oe, o, io, eoe;
  logic        m;
  int          n, sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic sbit(input logic bi, output logic miso, output logic [3:0] ios, output logic [3:0] oes);
    in_io = {3'b0, bi};
    tick(4);
    miso = out_io[1];
    ios  = out_io;
    oes  = out_io_oe;
    in_sclk = 1'b1;
    tick(4);
    in_sclk = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] tx, output logic [7:0] rxb, output logic [3:0] oes);
    logic mi;
    logic [3:0] ios;
    rxb = 8'h0;
    for (int i = 7; i >= 0; i--) begin
      sbit(tx[i], mi, ios, oes);
      rxb = {rxb[6:0], mi};
    end
  endtask

  // flash behaviour at transaction granularity; data bytes are right-aligned, first byte highest
  task automatic model(input logic [7:0] mop, input logic [23:0] ma, input int mn, input logic [31:0] md);
    case (mop)
      8'h06: m_wel = 1'b1;
      8'h04: m_wel = 1'b0;
      8'h31: begin
        if (m_wel && mn > 0) m_qe = md[8*(mn-1)+1];
        m_wel = 1'b0;
      end
      8'h02: begin
        if (m_wel)
          for (int i = 0; i < mn; i++) m_mem[(ma[7:0] + i) % 256] &= md[8*(mn-1-i) +: 8];
        m_wel = 1'b0;
      end
      8'hC7, 8'h60: begin
        if (m_wel) for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
        m_wel = 1'b0;
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] mop, input logic [23:0] ma, input int mn);
    logic [31:0] r;
    logic [7:0]  bb;
    r = 32'h0;
    for (int i = 0; i < mn; i++) begin
      case (mop)
        8'h05:   bb = {6'b0, m_wel, 1'b0};
        8'h35:   bb = {6'b0, m_qe, 1'b0};
        default: bb = m_mem[(ma[7:0] + i) % 256];
      endcase
      r = {r[23:0], bb};
    end
    return r;
  endfunction

  task automatic run_tx(input logic [7:0] top, input logic [23:0] ta, input int tn, input logic [31:0] td,
                        output logic [31:0] trx, output logic [3:0] toe);
    logic [7:0] bb;
    logic [3:0] oo, ii;
    logic       mm;
    trx = 32'h0;
    toe = 4'h0;
    in_cs_n = 1'b0;
    tick(4);
    sbyte(top, bb, oo);
    if (top inside {8'h03, 8'h02, 8'h6B})
      for (int i = 2; i >= 0; i--) sbyte(ta[8*i +: 8], bb, oo);
    if (top == 8'h6B) begin
      for (int i = 0; i < DUM; i++) sbit(1'b0, mm, ii, oo);
      for (int i = 0; i < 2*tn; i++) begin
        sbit(1'b0, mm, ii, oo);
        trx = {trx[27:0], ii};
        toe = oo;
      end
    end else if (top inside {8'h03, 8'h05, 8'h35}) begin
      for (int i = 0; i < tn; i++) begin
        sbyte(8'h00, bb, oo);
        trx = {trx[23:0], bb};
        toe = oo;
      end
    end else if (top inside {8'h02, 8'h31}) begin
      for (int i = 0; i < tn; i++) sbyte(td[8*(tn-1-i) +: 8], bb, oo);
    end
    tick(4);
    in_cs_n = 1'b1;
    tick(6);
    model(top, ta, tn, td);
  endtask

  task automatic rand_tx(input int k, input logic [7:0] rop, input logic [23:0] ra, input int rn, input logic [31:0] rd);
    logic [31:0] rexp, rrx;
    logic [3:0]  reoe, roe;
    rexp = m_read(rop, ra, rn);
    reoe = (rop == 8'h6B) ? (m_qe ? 4'hF : 4'h0) : 4'h2;
    run_tx(rop, ra, rn, rd, rrx, roe);
    if (rop inside {8'h03, 8'h05, 8'h35, 8'h6B}) begin
      chk($sformatf("rand%0d_op%h_oe", k, rop), roe, reoe);
      if (reoe != 4'h0) chk($sformatf("rand%0d_op%h_rx", k, rop), rrx, rexp);
    end
    chk($sformatf("rand%0d_wel", k), out_wel, m_wel);
    chk($sformatf("rand%0d_qe", k), out_qe, m_qe);
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: still running after %0d cycles, required to finish", 200000);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'hFF;
    m_wel = 1'b0;
    m_qe  = 1'b0;
    tbl.push_back('{8'h35, 24'h0,      1, 32'h0,      32'h00,       4'h2, 1'b0, 1'b0});
    tbl.push_back('{8'h06, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b0});
    tbl.push_back('{8'h05, 24'h0,      2, 32'h0,      32'h0202,     4'h2, 1'b1, 1'b0});
    tbl.push_back('{8'h04, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b0, 1'b0});
    tbl.push_back('{8'h05, 24'h0,      1, 32'h0,      32'h00,       4'h2, 1'b0, 1'b0});
    tbl.push_back('{8'h06, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b0});
    tbl.push_back('{8'h31, 24'h0,      1, 32'h02,     32'h0,        4'h0, 1'b0, 1'b1});
    tbl.push_back('{8'h35, 24'h0,      1, 32'h0,      32'h02,       4'h2, 1'b0, 1'b1});
    tbl.push_back('{8'h02, 24'h10,     2, 32'hA53C,   32'h0,        4'h0, 1'b0, 1'b1});
    tbl.push_back('{8'h03, 24'h10,     2, 32'h0,      32'hFFFF,     4'h2, 1'b0, 1'b1});
    tbl.push_back('{8'h06, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b1});
    tbl.push_back('{8'h02, 24'h10,     2, 32'hA53C,   32'h0,        4'h0, 1'b0, 1'b1});
    tbl.push_back('{8'h03, 24'h10,     2, 32'h0,      32'hA53C,     4'h2, 1'b0, 1'b1});
    tbl.push_back('{8'h06, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b1});
    tbl.push_back('{8'h02, 24'h10,     1, 32'h0F,     32'h0,        4'h0, 1'b0, 1'b1});
    tbl.push_back('{8'h03, 24'h10,     1, 32'h0,      32'h05,       4'h2, 1'b0, 1'b1});
    tbl.push_back('{8'h06, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b1});
    tbl.push_back('{8'h02, 24'hFF,     3, 32'h112233, 32'h0,        4'h0, 1'b0, 1'b1});
    tbl.push_back('{8'h03, 24'hFF,     3, 32'h0,      32'h112233,   4'h2, 1'b0, 1'b1});
    tbl.push_back('{8'h6B, 24'hFF,     2, 32'h0,      32'h1122,     4'hF, 1'b0, 1'b1});
    tbl.push_back('{8'h03, 24'h123401, 1, 32'h0,      32'h33,       4'h2, 1'b0, 1'b1});
    tbl.push_back('{8'h06, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b1});
    tbl.push_back('{8'h31, 24'h0,      1, 32'h00,     32'h0,        4'h0, 1'b0, 1'b0});
    tbl.push_back('{8'h6B, 24'h10,     1, 32'h0,      32'h0,        4'h0, 1'b0, 1'b0});
    tbl.push_back('{8'hC7, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b0, 1'b0});
    tbl.push_back('{8'h03, 24'h10,     1, 32'h0,      32'h05,       4'h2, 1'b0, 1'b0});
    tbl.push_back('{8'h06, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b0});
    tbl.push_back('{8'hC7, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b0, 1'b0});
    tbl.push_back('{8'h03, 24'h0,      4, 32'h0,      32'hFFFFFFFF, 4'h2, 1'b0, 1'b0});
    tbl.push_back('{8'h06, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b0});
    tbl.push_back('{8'h02, 24'h20,     1, 32'h00,     32'h0,        4'h0, 1'b0, 1'b0});
    tbl.push_back('{8'h03, 24'h20,     1, 32'h0,      32'h00,       4'h2, 1'b0, 1'b0});
    tbl.push_back('{8'h06, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b1, 1'b0});
    tbl.push_back('{8'h60, 24'h0,      0, 32'h0,      32'h0,        4'h0, 1'b0, 1'b0});
    tbl.push_back('{8'h03, 24'h1E,     4, 32'h0,      32'hFFFFFFFF, 4'h2, 1'b0, 1'b0});

    tick(3);
    rst = 1'b0;
    tick(3);
    chk("reset_io", out_io, 4'h0);
    chk("reset_oe", out_io_oe, 4'h0);
    chk("reset_wel", out_wel, 1'b0);
    chk("reset_qe", out_qe, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_tx(tbl[i].op, tbl[i].addr, tbl[i].n, tbl[i].data, rx, oe);
      if (tbl[i].op inside {8'h03, 8'h05, 8'h35, 8'h6B}) begin
        chk($sformatf("vec%0d_op%h_oe", i, tbl[i].op), oe, tbl[i].exp_oe);
        if (tbl[i].exp_oe != 4'h0) chk($sformatf("vec%0d_op%h_rx", i, tbl[i].op), rx, tbl[i].exp);
      end
      chk($sformatf("vec%0d_wel", i), out_wel, tbl[i].exp_wel);
      chk($sformatf("vec%0d_qe", i), out_qe, tbl[i].exp_qe);
    end

    // page program aborted four bits into its second data byte
    run_tx(8'h06, 24'h0, 0, 32'h0, rx, oe);
    in_cs_n = 1'b0;
    tick(4);
    sbyte(8'h02, b, o);
    sbyte(8'h00, b, o);
    sbyte(8'h00, b, o);
    sbyte(8'h40, b, o);
    sbyte(8'h5A, b, o);
    for (int i = 0; i < 4; i++) sbit(1'b0, m, io, o);
    tick(4);
    in_cs_n = 1'b1;
    tick(3);
    chk("abort_pp_oe", out_io_oe, 4'h0);
    chk("abort_pp_wel", out_wel, 1'b0);
    tick(3);
    m_mem[8'h40] = 8'h5A;
    m_wel = 1'b0;
    run_tx(8'h03, 24'h40, 2, 32'h0, rx, oe);
    chk("abort_pp_readback", rx, 32'h5AFF);

    // read aborted with CS rising in the same cycle as an SCLK fall
    in_cs_n = 1'b0;
    tick(4);
    sbyte(8'h03, b, o);
    sbyte(8'h00, b, o);
    sbyte(8'h00, b, o);
    sbyte(8'h40, b, o);
    sbyte(8'h00, b, o);
    chk("abort_rd_byte", b, 8'h5A);
    chk("abort_rd_oe_active", o, 4'h2);
    for (int i = 0; i < 3; i++) sbit(1'b0, m, io, o);
    in_cs_n = 1'b1;
    tick(2);
    chk("abort_rd_oe_2clk", out_io_oe, 4'h2);
    tick(1);
    chk("abort_rd_oe_3clk", out_io_oe, 4'h0);
    tick(6);

    for (int k = 0; k < 40; k++) begin
      sel  = $urandom_range(0, 9);
      addr = 24'($urandom);
      n    = $urandom_range(1, 4);
      data = $urandom;
      case (sel)
        0, 1, 2: op = 8'h02;
        3, 4, 5: op = 8'h03;
        6:       op = 8'h6B;
        7:       op = 8'h31;
        8:       op = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'h35;
        default: op = ($urandom_range(0, 3) == 0) ? 8'hC7 : 8'h04;
      endcase
      if (op inside {8'h02, 8'h31, 8'hC7} && $urandom_range(0, 3) != 0)
        rand_tx(k, 8'h06, 24'h0, 0, 32'h0);
      rand_tx(k, op, addr, n, data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
